// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the out-of-order core.
package uarch_pkg;

  localparam int unsigned TAG_WIDTH     = 6;
  localparam int unsigned PIPE_WIDTH    = 2;
  localparam int unsigned CPU_DATA_BITS = 32;
  localparam int unsigned NUM_FU        = 4;

  typedef enum logic [1:0] {
    FU_ALU0,
    FU_ALU1,
    FU_BRU,
    FU_LSU
  } fu_id_e;

  typedef struct packed {
    logic                     is_valid;
    logic [TAG_WIDTH-1:0]     dest_tag;
    logic [CPU_DATA_BITS-1:0] result;
    logic                     exception;
  } writeback_packet_t;

endpackage

// File: rtl/rr_pick2.sv
// Rotating priority find: first two set request bits at or after base, wrapping modulo N.
module rr_pick2 #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] base,
  output logic [$clog2(N)-1:0] idx0,
  output logic                 vld0,
  output logic [$clog2(N)-1:0] idx1,
  output logic                 vld1
);

  localparam int unsigned W = $clog2(N);

  always_comb begin
    int unsigned k;
    idx0 = '0;
    idx1 = '0;
    vld0 = 1'b0;
    vld1 = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      k = 32'(base) + j;
      if (k >= N) k = k - N;
      if (req[W'(k)]) begin
        if (!vld0) begin
          vld0 = 1'b1;
          idx0 = W'(k);
        end else if (!vld1) begin
          vld1 = 1'b1;
          idx1 = W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to two functional-unit results per cycle onto the registered CDB broadcast ports.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module cdb_arbiter
  import uarch_pkg::*;
#(
  parameter int unsigned NUM_FU  = uarch_pkg::NUM_FU,
  parameter int unsigned NUM_CDB = PIPE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic              [NUM_FU-1:0]      fu_valid,
  input  writeback_packet_t [NUM_FU-1:0]      fu_packets,
  output logic              [NUM_FU-1:0]      fu_ready,
  output writeback_packet_t [NUM_CDB-1:0]     cdb_ports,
  output logic              [$clog2(NUM_FU)-1:0] rr_ptr
);

  localparam int unsigned PtrW = $clog2(NUM_FU);

  logic              [NUM_FU-1:0]  req;
  logic              [PtrW-1:0]    base;
  logic              [PtrW-1:0]    idx0;
  logic              [PtrW-1:0]    idx1;
  logic                            vld0;
  logic                            vld1;
  logic                            vld1_used;
  writeback_packet_t [NUM_CDB-1:0] cdb_d;
  writeback_packet_t [NUM_CDB-1:0] cdb_q;

  // Nothing may transfer during reset or flush.
  assign req = (rst_n && !flush) ? fu_valid : '0;

  rr_pick2 #(
    .N (NUM_FU)
  ) u_pick (
    .req  (req),
    .base (base),
    .idx0 (idx0),
    .vld0 (vld0),
    .idx1 (idx1),
    .vld1 (vld1)
  );

  assign vld1_used = (NUM_CDB > 1) && vld1;

  always_comb begin
    fu_ready = '0;
    if (vld0)      fu_ready[idx0] = 1'b1;
    if (vld1_used) fu_ready[idx1] = 1'b1;
  end

  // Second grant goes to the last port; with a single port it is never used.
  always_comb begin
    cdb_d = '0;
    if (vld0) begin
      cdb_d[0]          = fu_packets[idx0];
      cdb_d[0].is_valid = 1'b1;
    end
    if (vld1_used) begin
      cdb_d[NUM_CDB-1]          = fu_packets[idx1];
      cdb_d[NUM_CDB-1].is_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q <= '0;
    end else begin
      cdb_q <= cdb_d;
    end
  end

  assign cdb_ports = cdb_q;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PtrW-1:0] rr_ptr_d;
  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] last_idx;

  assign last_idx = vld1_used ? idx1 : idx0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (vld0) begin
      rr_ptr_d = (32'(last_idx) == NUM_FU - 1) ? '0 : last_idx + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign base   = rr_ptr_q;
  assign rr_ptr = rr_ptr_q;
`else
  assign base   = '0;
  assign rr_ptr = '0;
`endif

`ifndef SYNTHESIS
  logic dup_tag;

  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      for (int j = i + 1; j < NUM_FU; j++) begin
        if (fu_valid[i] && fu_valid[j] &&
            fu_packets[i].dest_tag == fu_packets[j].dest_tag) begin
          dup_tag = 1'b1;
        end
      end
    end
  end

  dup_tag_a: assert property (@(posedge clk) disable iff (!rst_n) !dup_tag);
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter; follows CDB_ROUND_ROBIN_EN to pick the expected arbitration.
module tb_cdb_arbiter;
  import uarch_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    flush = 1'b0;
  logic              [3:0] fu_valid = '0;
  writeback_packet_t [3:0] fu_packets = '0;
  logic              [3:0] fu_ready;
  writeback_packet_t [1:0] cdb_ports;
  logic              [1:0] rr_ptr;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_packets (fu_packets),
    .fu_ready   (fu_ready),
    .cdb_ports  (cdb_ports),
    .rr_ptr     (rr_ptr)
  );

  typedef struct {
    writeback_packet_t p0;
    writeback_packet_t p1;
    logic [1:0]        ptr;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] mptr = 2'd0;

`ifdef CDB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  function automatic writeback_packet_t mk(input int tag, input logic [31:0] res, input logic exc);
    writeback_packet_t p;
    p.is_valid  = 1'b1;
    p.dest_tag  = 6'(tag);
    p.result    = res;
    p.exception = exc;
    return p;
  endfunction

  // Reference arbiter: walks sources from the start point, taking at most two.
  function automatic logic [3:0] model(input logic [3:0] v, input logic fl, input logic [1:0] ptr,
                                       input writeback_packet_t [3:0] pk, output exp_t e);
    logic [3:0]        rdy;
    writeback_packet_t p;
    int                idx;
    int                cnt;
    int                last;
    rdy   = '0;
    e.p0  = '0;
    e.p1  = '0;
    e.ptr = ptr;
    if (fl) begin
      e.ptr = 2'd0;
      return rdy;
    end
    idx  = Rr ? int'(ptr) : 0;
    cnt  = 0;
    last = 0;
    for (int n = 0; n < 4; n++) begin
      if (v[idx] && cnt < 2) begin
        p          = pk[idx];
        p.is_valid = 1'b1;
        if (cnt == 0) e.p0 = p;
        else          e.p1 = p;
        rdy[idx] = 1'b1;
        cnt++;
        last = idx;
      end
      idx = (idx + 1) % 4;
    end
    if (Rr && cnt > 0) e.ptr = 2'((last + 1) % 4);
    return rdy;
  endfunction

  task automatic predict(output logic [3:0] rdy);
    exp_t e;
    rdy = model(fu_valid, flush, mptr, fu_packets, e);
    sb.push_back(e);
    mptr = e.ptr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) fu_packets[i] = mk(10 + i, 32'h1000 + i, 1'b0);
    #1;
    n_cmp++;
    if (fu_ready !== 4'b0000 || cdb_ports !== '0 || rr_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: ready=%b ports=%h ptr=%0d, want 0/0/0", fu_ready, cdb_ports, rr_ptr);
    end
    tick();
    tick();
    n_cmp++;
    if (fu_ready !== 4'b0000 || cdb_ports !== '0 || rr_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL reset_held: ready=%b ports=%h ptr=%0d, want 0/0/0", fu_ready, cdb_ports, rr_ptr);
    end
    fu_valid = '0;
    rst_n    = 1'b1;
    mptr     = 2'd0;
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    exp_t       e;
    fu_valid      = 4'b0100;
    fu_packets[2] = mk(5, 32'hAAAA_AAAA, 1'b0);
    @(negedge clk);
    predict(rdy);
    n_cmp++;
    if (fu_ready !== 4'b0100 || fu_ready !== rdy) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0100 (model %b)", fu_ready, rdy);
    end
    tick();
    fu_valid = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cdb_ports[0] !== {1'b1, 6'd5, 32'hAAAA_AAAA, 1'b0} || cdb_ports[1].is_valid !== 1'b0 ||
        rr_ptr !== (Rr ? 2'd3 : 2'd0) || cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1) begin
      n_err++;
      $display("FAIL single_out: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
               cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
    end
    // Idle cycle: the broadcast must not linger.
    @(negedge clk);
    predict(rdy);
    tick();
    e = sb.pop_front();
    n_cmp++;
    if (cdb_ports !== '0 || rr_ptr !== e.ptr) begin
      n_err++;
      $display("FAIL single_oneshot: ports=%h ptr=%0d want 0 ptr=%0d", cdb_ports, rr_ptr, e.ptr);
    end
  endtask

  task automatic test_four();
    logic [3:0] rdy;
    exp_t       e;
    flush = 1'b1;
    @(negedge clk);
    predict(rdy);
    tick();
    e     = sb.pop_front();
    flush = 1'b0;
    n_cmp++;
    if (rr_ptr !== 2'd0 || cdb_ports !== '0) begin
      n_err++;
      $display("FAIL four_preflush: ptr=%0d ports=%h want 0/0", rr_ptr, cdb_ports);
    end
    fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) fu_packets[i] = mk(i, 32'h5000 + i, i == 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      predict(rdy);
      n_cmp++;
      if (fu_ready !== rdy || fu_ready !== (c == 0 ? 4'b0011 : 4'b1100)) begin
        n_err++;
        $display("FAIL four_ready_c%0d: got %b want %b", c, fu_ready, rdy);
      end
      tick();
      fu_valid = fu_valid & ~rdy;
      e = sb.pop_front();
      n_cmp++;
      if (cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1 || rr_ptr !== e.ptr ||
          cdb_ports[0].dest_tag !== 6'(2 * c) || cdb_ports[1].dest_tag !== 6'(2 * c + 1) ||
          rr_ptr !== ((Rr && c == 0) ? 2'd2 : 2'd0)) begin
        n_err++;
        $display("FAIL four_out_c%0d: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
                 c, cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rdy;
    exp_t       e;
    fu_valid      = 4'b0100;
    fu_packets[2] = mk(9, 32'h0909_0909, 1'b0);
    @(negedge clk);
    predict(rdy);
    tick();
    fu_valid = '0;
    e = sb.pop_front();
    n_cmp++;
    if (rr_ptr !== (Rr ? 2'd3 : 2'd0) || cdb_ports[0] !== e.p0) begin
      n_err++;
      $display("FAIL wrap_setup: ptr=%0d p0=%h want ptr=%0d p0=%h", rr_ptr, cdb_ports[0], e.ptr, e.p0);
    end
    fu_valid      = 4'b1001;
    fu_packets[3] = mk(7, 32'h7777_0000, 1'b0);
    fu_packets[0] = mk(6, 32'h6666_0000, 1'b1);
    @(negedge clk);
    predict(rdy);
    n_cmp++;
    if (fu_ready !== 4'b1001 || fu_ready !== rdy) begin
      n_err++;
      $display("FAIL wrap_ready: got %b want 1001", fu_ready);
    end
    tick();
    fu_valid = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1 || rr_ptr !== e.ptr ||
        cdb_ports[0].dest_tag !== (Rr ? 6'd7 : 6'd6) || cdb_ports[1].dest_tag !== (Rr ? 6'd6 : 6'd7) ||
        rr_ptr !== (Rr ? 2'd1 : 2'd0)) begin
      n_err++;
      $display("FAIL wrap_out: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
               cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
    end
  endtask

  task automatic test_flush();
    logic [3:0] rdy;
    exp_t       e;
    fu_valid      = 4'b0011;
    fu_packets[0] = mk(20, 32'h2020_2020, 1'b0);
    fu_packets[1] = mk(21, 32'h2121_2121, 1'b0);
    flush         = 1'b1;
    @(negedge clk);
    predict(rdy);
    n_cmp++;
    if (fu_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_ready: got %b want 0000", fu_ready);
    end
    tick();
    flush = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (cdb_ports !== '0 || rr_ptr !== 2'd0 || rr_ptr !== e.ptr) begin
      n_err++;
      $display("FAIL flush_out: ports=%h ptr=%0d want 0/0", cdb_ports, rr_ptr);
    end
    @(negedge clk);
    predict(rdy);
    n_cmp++;
    if (fu_ready !== 4'b0011 || fu_ready !== rdy) begin
      n_err++;
      $display("FAIL flush_resume_ready: got %b want 0011", fu_ready);
    end
    tick();
    fu_valid = '0;
    e = sb.pop_front();
    n_cmp++;
    if (cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1 || rr_ptr !== e.ptr ||
        cdb_ports[0].dest_tag !== 6'd20 || cdb_ports[1].dest_tag !== 6'd21) begin
      n_err++;
      $display("FAIL flush_resume_out: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
               cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] rdy;
    exp_t       e;
    int         tag = 40;
    fu_valid      = 4'b1011;
    fu_packets[3] = mk(63, 32'h3333_3333, 1'b0);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!Rr || c == 0 || !fu_valid[i]) begin
          fu_packets[i] = mk(tag, 32'(tag * 3), 1'b0);
          fu_valid[i]   = 1'b1;
          tag++;
        end
      end
      @(negedge clk);
      predict(rdy);
      n_cmp++;
      if (fu_ready !== rdy || (!Rr && fu_ready !== 4'b0011)) begin
        n_err++;
        $display("FAIL prio_ready_c%0d: got %b want %b", c, fu_ready, rdy);
      end
      tick();
      fu_valid = fu_valid & ~rdy;
      e = sb.pop_front();
      n_cmp++;
      if (cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1 || rr_ptr !== e.ptr) begin
        n_err++;
        $display("FAIL prio_out_c%0d: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
                 c, cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
      end
    end
    fu_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] rdy;
    exp_t       e;
    fu_valid      = 4'b0011;
    fu_packets[0] = mk(30, 32'h3030_3030, 1'b0);
    fu_packets[1] = mk(31, 32'h3131_3131, 1'b1);
    @(negedge clk);
    predict(rdy);
    tick();
    e = sb.pop_front();
    n_cmp++;
    if (cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1 || rr_ptr !== e.ptr) begin
      n_err++;
      $display("FAIL rstmid_pre: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
               cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
    end
    fu_valid      = 4'b1100;
    fu_packets[2] = mk(32, 32'h3232_3232, 1'b0);
    fu_packets[3] = mk(33, 32'h3333_0033, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (fu_ready !== 4'b1100) begin
      n_err++;
      $display("FAIL rstmid_ready: got %b want 1100", fu_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fu_ready !== 4'b0000 || cdb_ports !== '0 || rr_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL rstmid_async: ready=%b ports=%h ptr=%0d want 0/0/0", fu_ready, cdb_ports, rr_ptr);
    end
    tick();
    n_cmp++;
    if (cdb_ports !== '0 || rr_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL rstmid_discard: ports=%h ptr=%0d want 0/0", cdb_ports, rr_ptr);
    end
    fu_valid = '0;
    rst_n    = 1'b1;
    mptr     = 2'd0;
  endtask

  task automatic test_random();
    logic [3:0] rdy;
    exp_t       e;
    int         nt = 0;
    bit         clash;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!fu_valid[i] && $urandom_range(0, 2) != 0) begin
          do begin
            nt    = (nt + 1) % 64;
            clash = 1'b0;
            for (int j = 0; j < 4; j++) begin
              if (fu_valid[j] && fu_packets[j].dest_tag == 6'(nt)) clash = 1'b1;
            end
          end while (clash);
          fu_packets[i] = mk(nt, $urandom, 1'($urandom_range(0, 1)));
          fu_valid[i]   = 1'b1;
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      predict(rdy);
      n_cmp++;
      if (fu_ready !== rdy) begin
        n_err++;
        $display("FAIL rand_ready_%0d: got %b want %b", cyc, fu_ready, rdy);
      end
      tick();
      fu_valid = fu_valid & ~rdy;
      if (flush) fu_valid = fu_valid & 4'($urandom);
      flush = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (cdb_ports[0] !== e.p0 || cdb_ports[1] !== e.p1 || rr_ptr !== e.ptr) begin
        n_err++;
        $display("FAIL rand_out_%0d: p0=%h p1=%h ptr=%0d want p0=%h p1=%h ptr=%0d",
                 cyc, cdb_ports[0], cdb_ports[1], rr_ptr, e.p0, e.p1, e.ptr);
      end
    end
    fu_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_wrap();
    test_flush();
    test_fixed_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Collects completed results from the functional units and drives up to `PIPE_WIDTH` (2) registered `writeback_packet_t` broadcasts per cycle onto the CDB ports.
- The CDB ports feed the ROB `cdb_ports` input and the reservation-station wakeup logic.
- It is the producer end of the writeback interface: functional units present results with valid/ready, and the arbiter grants, registers and broadcasts them.
- On `flush` it drops everything in flight.

## Interface
Parameters:
- `NUM_FU`, default 4: number of functional-unit result sources (ALU0, ALU1, BRU, LSU); legal range 2..8.
- `NUM_CDB`, default `PIPE_WIDTH` (2): number of CDB broadcast ports.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  ROB mispredict/exception flush.
- `fu_valid`  in  `NUM_FU`  source i holds a completed result.
- `fu_packets`  in  `writeback_packet_t [NUM_FU]`  result per source: `is_valid`, `dest_tag`, `result`, `exception`.
- `fu_ready`  out  `NUM_FU`  source i is granted this cycle; combinational.
- `cdb_ports`  out  `writeback_packet_t [NUM_CDB]`  registered broadcast.
- `rr_ptr`  out  `$clog2(NUM_FU)`  current highest-priority source, for debug.

## Operation
Handshake:
- A transfer occurs on source i when `fu_valid[i] && fu_ready[i]` at a rising edge.
- A source holds `fu_valid` and its packet stable until it is granted.
- `fu_ready` may depend combinationally on `fu_valid`.

Arbitration:
- Scan sources starting at `rr_ptr` in ascending index, modulo `NUM_FU`.
- The first valid source found is granted to CDB port 0, the second to port 1.
- At most `NUM_CDB` grants per cycle.
- With a single winner, port 1 carries `is_valid`=0.

Output register:
- At the edge, each granted packet is copied into `cdb_ports[k]` with `is_valid`=1.
- Ungranted ports load all-zero.
- `cdb_ports` is never held across cycles; each packet is broadcast for exactly one cycle.

Pointer update:
- If any grant occurs, `rr_ptr` becomes (index of last granted source + 1) mod `NUM_FU`.
- If no grant occurs, `rr_ptr` is unchanged.

Flush:
- While `flush`=1, `fu_ready` is all 0 and nothing transfers.
- At the edge, `cdb_ports` loads all-zero and `rr_ptr` is reset to 0.
- Sources are responsible for squashing their own pending results.

Duplicate tags:
- Two sources presenting the same `dest_tag` in one cycle is illegal.
- A simulation-only assertion flags it.

Reset:
- `rst_n`=0 clears `cdb_ports` to all-zero and `rr_ptr` to 0 immediately.
- `fu_ready` is 0 while in reset.
- Reset asserted mid-operation discards any packet granted in that cycle.

## Timing
- Latency is 1 cycle: a packet granted at edge t appears on `cdb_ports` during cycle t+1.
- Throughput is `NUM_CDB` results per cycle.
- Starvation is bounded: any continuously valid source is granted within `ceil(NUM_FU/NUM_CDB)` cycles (round-robin build).
- `flush` and grants in the same cycle: `flush` wins and there are no grants.
- `rr_ptr` wrap-around: with pointer at `NUM_FU`-1 and sources `NUM_FU`-1 and 0 valid, port 0 carries source `NUM_FU`-1 and port 1 carries source 0.

## Configuration
Macro `CDB_ROUND_ROBIN_EN`:
- Defined: round-robin arbitration as described; `rr_ptr` is live.
- Undefined: fixed priority with the lowest index first, the scan always starts at 0, `rr_ptr` is tied to 0 and no pointer register is built.
- All other behaviour is identical in both builds.

## Structure
Shared package `uarch_pkg`:
- Existing: `writeback_packet_t`, `TAG_WIDTH`, `PIPE_WIDTH`, `CPU_DATA_BITS`.
- New: `NUM_FU` constant and the `fu_id_e` enum (FU_ALU0, FU_ALU1, FU_BRU, FU_LSU).

Sub-module `rr_pick2`:
- Combinational rotate/priority-find that returns the first two set bits of a request vector, starting from a base index.
- Returns their indices with per-grant valid bits.

## Test plan
- **Reset:** hold `rst_n`=0 with all `fu_valid`=1 → `fu_ready`=0, `cdb_ports` all `is_valid`=0, `rr_ptr`=0.
- **Single source:** source 2 valid, tag 5, result 0xAAAAAAAA → `fu_ready`=4'b0100; next cycle port0={1,5,0xAAAAAAAA,0}, port1 invalid; `rr_ptr`=3.
- **Four sources valid, tags 0..3, `rr_ptr`=0:**
  - Cycle 1: grants 0 and 1; next cycle ports carry tags 0 and 1; `rr_ptr`=2.
  - Cycle 2: grants 2 and 3; next cycle ports carry tags 2 and 3; `rr_ptr`=0.
- **Wrap:** `rr_ptr`=3, sources 3 and 0 valid (tags 7 and 6) → port0 tag 7, port1 tag 6; `rr_ptr`=1.
- **Flush:** sources 0 and 1 valid with `flush`=1 → `fu_ready`=0; next cycle ports invalid and `rr_ptr`=0; after the flush drops, the sources are granted normally.
- **Fixed-priority build** (no `CDB_ROUND_ROBIN_EN`): sources 0, 1 and 3 valid and held for 3 cycles → sources 0 and 1 are granted every cycle and source 3 is never granted.
